// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the inverse-cipher datapath.
// Byte 0 of a 128-bit block is [127:120]; bytes are column-major (index = row + 4*col).
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_ADDK,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    // Indexed directly by the round counter; entry 0 and 11..15 are never used.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul_e(a0) ^ gf_mul_b(a1) ^ gf_mul_d(a2) ^ gf_mul_9(a3);
            o[119 - 32*c -: 8] = gf_mul_9(a0) ^ gf_mul_e(a1) ^ gf_mul_b(a2) ^ gf_mul_d(a3);
            o[111 - 32*c -: 8] = gf_mul_d(a0) ^ gf_mul_9(a1) ^ gf_mul_e(a2) ^ gf_mul_b(a3);
            o[103 - 32*c -: 8] = gf_mul_b(a0) ^ gf_mul_d(a1) ^ gf_mul_9(a2) ^ gf_mul_e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box (combinational): inverse affine map followed by the GF inverse.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] s
);
    logic [7:0] y;

    assign y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    assign s = gf_inv(y);
endmodule

// File: rtl/aes_sbox.sv
// Encryption-side AES S-box (combinational): GF inverse followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] s
);
    logic [7:0] b;

    assign b = gf_inv(x);
    assign s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 decryption core, one round per clock, round keys derived on the fly.
// Optional AES_KEY_CACHE_EN keeps the last key's round key 10 to skip the forward expansion.
module aes128_inv_cipher
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);
    localparam int unsigned RCW = $clog2(NR + 2);

    state_t         state, state_nx;
    logic [127:0]   key_r, st_r, knext, kfwd, isr, isb, key_load;
    logic [RCW-1:0] rc;
    logic [31:0]    sw_in, sw_out, rcw;
    logic [31:0]    f0, f1, f2, f3;
    logic           accept, hit;

    assign rcw = {RCON[rc], 24'h0};

    // Forward and inverse key steps share the four S-boxes; only the SubWord source differs.
    assign sw_in = rot_word((state == S_KEXP) ? key_r[31:0] : (key_r[31:0] ^ key_r[63:32]));

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.x(sw_in[8*i +: 8]), .s(sw_out[8*i +: 8]));
    end

    assign f0   = key_r[127:96] ^ sw_out ^ rcw;
    assign f1   = key_r[95:64] ^ f0;
    assign f2   = key_r[63:32] ^ f1;
    assign f3   = key_r[31:0] ^ f2;
    assign kfwd = {f0, f1, f2, f3};

    assign knext = {key_r[127:96] ^ sw_out ^ rcw,
                    key_r[95:64] ^ key_r[127:96],
                    key_r[63:32] ^ key_r[95:64],
                    key_r[31:0]  ^ key_r[63:32]};

    assign isr = inv_shift_rows(st_r);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.x(isr[8*i +: 8]), .s(isb[8*i +: 8]));
    end

    assign accept = in_valid && in_ready;

`ifdef AES_KEY_CACHE_EN
    logic [127:0] cache_key, cache_rk;
    logic         cache_valid;

    assign hit      = cache_valid && (key == cache_key);
    assign key_load = hit ? cache_rk : key;

    // A miss invalidates the entry at accept; it only becomes valid once KEXP completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_rk    <= '0;
        end else if (accept && !hit) begin
            cache_valid <= 1'b0;
            cache_key   <= key;
        end else if (state == S_KEXP && rc == RCW'(NR)) begin
            cache_valid <= 1'b1;
            cache_rk    <= kfwd;
        end
    end
`else
    assign hit      = 1'b0;
    assign key_load = key;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == S_IDLE) && !rst;
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
        case (state)
            S_IDLE:  if (accept) state_nx = hit ? S_ADDK : S_KEXP;
            S_KEXP:  if (rc == RCW'(NR)) state_nx = S_ADDK;
            S_ADDK:  state_nx = S_ROUND;
            S_ROUND: if (rc == RCW'(2)) state_nx = S_FINAL;
            S_FINAL: state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_r <= '0;
            st_r  <= '0;
            rc    <= '0;
            pt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    key_r <= key_load;
                    st_r  <= ct;
                    rc    <= RCW'(1);
                end
                S_KEXP: begin
                    key_r <= kfwd;
                    rc    <= rc + RCW'(1);
                end
                S_ADDK: begin
                    st_r <= st_r ^ key_r;
                    rc   <= RCW'(NR);
                end
                S_ROUND: begin
                    st_r  <= inv_mix_columns(isb ^ knext);
                    key_r <= knext;
                    rc    <= rc - RCW'(1);
                end
                S_FINAL: pt <= isb ^ knext;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Self-checking bench for aes128_inv_cipher against a table-driven FIPS-197 InvCipher model.
module tb_aes128_inv_cipher;
    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, in_ready, out_valid, busy;
    logic [127:0] key, ct, pt;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    bit           cache_v = 1'b0;
    logic [127:0] cache_k = '0;

`ifdef AES_KEY_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

    aes128_inv_cipher #(.NR(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .ct(ct), .out_valid(out_valid), .out_ready(out_ready),
        .pt(pt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        while (bb != 0) begin
            if (bb[0]) p ^= aa;
            aa = m_xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox[x] = s;
            isbox[s] = 8'(x);
        end
    endfunction

    function automatic void ref_decrypt(input logic [127:0] k, input logic [127:0] c,
                                        output logic [127:0] p, output logic [127:0] rk10);
        logic [31:0]  w [44];
        logic [127:0] rk [11];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rcon = 8'h01;
        logic [31:0]  tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]] ^ rcon, sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                rcon = m_xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk10 = rk[10];
        for (int i = 0; i < 16; i++) s[i] = c[127 - 8*i -: 8] ^ rk[10][127 - 8*i -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*col] = isbox[s[row + 4*((col + 4 - row) % 4)]];
            for (int i = 0; i < 16; i++) t[i] ^= rk[rnd][127 - 8*i -: 8];
            if (rnd > 0) begin
                for (int col = 0; col < 4; col++) begin
                    s[4*col]   = gmul(14, t[4*col]) ^ gmul(11, t[4*col+1]) ^ gmul(13, t[4*col+2]) ^ gmul(9, t[4*col+3]);
                    s[4*col+1] = gmul(9, t[4*col]) ^ gmul(14, t[4*col+1]) ^ gmul(11, t[4*col+2]) ^ gmul(13, t[4*col+3]);
                    s[4*col+2] = gmul(13, t[4*col]) ^ gmul(9, t[4*col+1]) ^ gmul(14, t[4*col+2]) ^ gmul(11, t[4*col+3]);
                    s[4*col+3] = gmul(11, t[4*col]) ^ gmul(13, t[4*col+1]) ^ gmul(9, t[4*col+2]) ^ gmul(14, t[4*col+3]);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        for (int i = 0; i < 16; i++) p[127 - 8*i -: 8] = s[i];
    endfunction

    function automatic int unsigned exp_latency(input logic [127:0] k);
        return (CACHE_ON && cache_v && cache_k == k) ? 21 - 10 : 21;
    endfunction

    // Caller is positioned at a negedge with the DUT idle.
    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] c,
                             input logic [127:0] exp_pt, input logic [127:0] exp_rk,
                             input int unsigned hold);
        int unsigned lat, cyc;
        lat = exp_latency(k);
        if (!(CACHE_ON && cache_v && cache_k == k)) cache_v = 1'b0;
        in_valid = 1'b1; key = k; ct = c;
        @(posedge clk); #1;
        in_valid = 1'b0; key = {$urandom, $urandom, $urandom, $urandom}; ct = {$urandom, $urandom, $urandom, $urandom};
        cyc = 0;
        forever begin
            @(negedge clk);
            if (cyc == 0) begin
                check({tag, "_busy"}, busy, 1);
                check({tag, "_in_ready_busy"}, in_ready, 0);
            end
            if (cyc == lat - 11) check({tag, "_key_r_addk"}, dut.key_r, exp_rk);
            if (out_valid || cyc >= 60) break;
            @(posedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_pt"}, pt, exp_pt);
        for (int unsigned i = 0; i < hold; i++) begin
            in_valid = 1'b1; key = C_KEY; ct = C_CT;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_pt"}, pt, exp_pt);
            check({tag, "_hold_out_valid"}, out_valid, 1);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_out_valid"}, out_valid, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
        check({tag, "_post_busy"}, busy, 0);
        check({tag, "_post_pt_kept"}, pt, exp_pt);
        cache_v = 1'b1;
        cache_k = k;
    endtask

    initial begin
        logic [127:0] rk, ep, ep2, rk2, rk_b, rk_c, rk_u, rk_v, k_rand, c_rand;
        int unsigned  cyc, c1, lat_b;

        build_sbox();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = '0; ct = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_pt", pt, 0);

        ref_decrypt(B_KEY, B_CT, ep, rk_b);
        ref_decrypt(C_KEY, C_CT, ep2, rk_c);
        check("model_b_rk10", rk_b, B_RK);

        run_block("app_b", B_KEY, B_CT, B_PT, B_RK, 0);
        run_block("app_c", C_KEY, C_CT, C_PT, rk_c, 0);
        run_block("app_b_bp", B_KEY, B_CT, B_PT, B_RK, 5);
        run_block("app_b_again", B_KEY, B_CT, B_PT, B_RK, 0);
        run_block("app_c_again", C_KEY, C_CT, C_PT, rk_c, 1);

        // Abort mid-operation with a synchronous reset.
        in_valid = 1'b1; key = B_KEY; ct = B_CT;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cache_v = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_pt", pt, 0);
        run_block("app_b_after_abort", B_KEY, B_CT, B_PT, B_RK, 0);

        // Back-to-back with in_valid held high across the first block.
        lat_b = exp_latency(B_KEY);
        if (!(CACHE_ON && cache_v && cache_k == B_KEY)) cache_v = 1'b0;
        in_valid = 1'b1; key = B_KEY; ct = B_CT;
        @(posedge clk); #1;
        key = C_KEY; ct = C_CT; out_ready = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (out_valid || cyc >= 60) break;
            @(posedge clk);
            cyc++;
        end
        check("b2b_first_latency", cyc, lat_b);
        check("b2b_first_pt", pt, B_PT);
        cache_v = 1'b1; cache_k = B_KEY;
        c1 = cyc;
        @(posedge clk); cyc++;
        @(negedge clk);
        check("b2b_gap_out_valid", out_valid, 0);
        forever begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (out_valid || cyc >= c1 + 80) break;
        end
        in_valid = 1'b0;
        check("b2b_second_interval", cyc - c1, 2 + 21);
        check("b2b_second_pt", pt, C_PT);
        @(posedge clk); #1;
        out_ready = 1'b0;
        cache_v = 1'b1; cache_k = C_KEY;
        @(negedge clk);
        check("b2b_end_in_ready", in_ready, 1);
        check("b2b_end_busy", busy, 0);

        // Random blocks, including a repeated key to exercise the cached path.
        for (int n = 0; n < 6; n++) begin
            if (n == 3) k_rand = rk_u;
            else        k_rand = {$urandom, $urandom, $urandom, $urandom};
            c_rand = {$urandom, $urandom, $urandom, $urandom};
            ref_decrypt(k_rand, c_rand, ep, rk);
            rk_u = k_rand;
            run_block($sformatf("rand%0d", n), k_rand, c_rand, ep, rk, $urandom_range(0, 3));
        end
        ref_decrypt(rk_u, B_CT, ep2, rk_v);
        run_block("rand_repeat_key", rk_u, B_CT, ep2, rk_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
